// File: rtl/mux_arb_nxw_pkg.sv
// Shared types and helpers for the N-channel registered data selector.
// Contents:
//   mux_mode_t     selection mode: MUX_SEL explicit index, MUX_RR round-robin
//   MUX_DEF_NCH    default channel count
//   MUX_DEF_DW     default data width
//   sel_width()    width of a channel index (at least 1 bit)
//   wrap_add()     (a + b) mod n for small non-negative operands, a < n, b < n
package mux_arb_nxw_pkg;

  typedef enum logic {
    MUX_SEL = 1'b0,
    MUX_RR  = 1'b1
  } mux_mode_t;

  localparam int MUX_DEF_NCH = 3;
  localparam int MUX_DEF_DW  = 16;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Single conditional subtract is enough because both operands are below n.
  function automatic int wrap_add(input int a, input int b, input int n);
    return ((a + b) >= n) ? (a + b - n) : (a + b);
  endfunction

endpackage

// File: rtl/mux_arb_nxw_if.sv
// Channel and output-stage bundle of the N-channel registered data selector.
// Modports:
//   master  source/consumer side: drives mode, select, channel valid/data and m_ready_in
//   slave   selector side: drives ready_out and the registered output stage
// Signals:
//   mode_in, sel_in       selection mode and explicit channel index
//   valid_in, d_in        per-channel valid, packed channel data (channel i at [i*DW +: DW])
//   ready_out             per-channel accept strobe
//   m_out, m_ch_out       registered selected data and source channel index
//   m_valid_out           output stage holds valid data
//   m_ready_in            consumer takes m_out this cycle
interface mux_arb_nxw_if #(
  parameter int N_CH = mux_arb_nxw_pkg::MUX_DEF_NCH,
  parameter int DW   = mux_arb_nxw_pkg::MUX_DEF_DW
) ();
  import mux_arb_nxw_pkg::*;

  localparam int SELW = sel_width(N_CH);

  mux_mode_t             mode_in;
  logic [SELW-1:0]       sel_in;
  logic [N_CH-1:0]       valid_in;
  logic [N_CH*DW-1:0]    d_in;
  logic [N_CH-1:0]       ready_out;
  logic [DW-1:0]         m_out;
  logic [SELW-1:0]       m_ch_out;
  logic                  m_valid_out;
  logic                  m_ready_in;

  modport master (
    output mode_in, sel_in, valid_in, d_in, m_ready_in,
    input  ready_out, m_out, m_ch_out, m_valid_out
  );

  modport slave (
    input  mode_in, sel_in, valid_in, d_in, m_ready_in,
    output ready_out, m_out, m_ch_out, m_valid_out
  );

endinterface

// File: rtl/mux_arb_nxw_rr_pick.sv
// rr_pick_nch: combinational rotate-priority search.
// Finds the first requesting channel starting at ptr and wrapping modulo N_CH.
// Ports:
//   req        in   N_CH   request vector
//   ptr        in   SELW   search start index (always < N_CH)
//   gnt_valid  out  1      some channel requested
//   gnt_idx    out  SELW   chosen channel (don't-care when gnt_valid=0)
module rr_pick_nch
  import mux_arb_nxw_pkg::*;
#(
  parameter int N_CH = MUX_DEF_NCH,
  parameter int SELW = sel_width(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [SELW-1:0] ptr,
  output logic            gnt_valid,
  output logic [SELW-1:0] gnt_idx
);

  logic            gnt_valid_s;
  logic [SELW-1:0] gnt_idx_s;

  // Scan offsets from farthest to nearest so the nearest requester overwrites last.
  always_comb begin
    gnt_valid_s = 1'b0;
    gnt_idx_s   = {SELW{1'b0}};
    for (int j = N_CH - 1; j >= 0; j--) begin
      gnt_valid_s = gnt_valid_s | req[wrap_add(int'(ptr), j, N_CH)];
      gnt_idx_s   = req[wrap_add(int'(ptr), j, N_CH)]
                    ? SELW'(wrap_add(int'(ptr), j, N_CH)) : gnt_idx_s;
    end
  end

  assign gnt_valid = gnt_valid_s;
  assign gnt_idx   = gnt_idx_s;

endmodule

// File: rtl/mux_arb_nxw.sv
// mux_arb_nxw: N-channel, DW-bit registered data selector with valid/ready handshake.
// Grants one channel per cycle, either the explicitly selected one or round-robin
// among requesters, and captures its data into a one-entry output register.
// Ports:
//   clk   in  1   system clock, all state on rising edge
//   rst   in  1   synchronous active-high reset
//   bus   slave modport of mux_arb_nxw_if (mode, select, channels, output stage)
module mux_arb_nxw
  import mux_arb_nxw_pkg::*;
#(
  parameter int N_CH = MUX_DEF_NCH,
  parameter int DW   = MUX_DEF_DW
) (
  input logic           clk,
  input logic           rst,
  mux_arb_nxw_if.slave  bus
);

  localparam int SELW = sel_width(N_CH);

  logic [DW-1:0]   m_out_r;
  logic [SELW-1:0] m_ch_r;
  logic            m_valid_r;
  logic [SELW-1:0] rr_ptr_r;

  logic            load_s;
  logic            rr_gv_s;
  logic [SELW-1:0] rr_idx_s;
  logic            grant_s;
  logic [SELW-1:0] g_s;
  logic [DW-1:0]   d_sel_s;
  logic [N_CH-1:0] ready_s;

  // Output stage can take a new item when empty or being drained this cycle.
  assign load_s = !m_valid_r || bus.m_ready_in;

  rr_pick_nch #(
    .N_CH (N_CH),
    .SELW (SELW)
  ) u_rr_pick (
    .req       (bus.valid_in),
    .ptr       (rr_ptr_r),
    .gnt_valid (rr_gv_s),
    .gnt_idx   (rr_idx_s)
  );

  // Grant source: explicit index (out-of-range index means no grant) or round-robin pick.
  always_comb begin
    grant_s = 1'b0;
    g_s     = {SELW{1'b0}};
    case (bus.mode_in)
      MUX_SEL: begin
        g_s = bus.sel_in;
        if (int'(bus.sel_in) < N_CH) begin
          grant_s = bus.valid_in[bus.sel_in];
        end else begin
          grant_s = 1'b0;
        end
      end
      MUX_RR: begin
        g_s     = rr_idx_s;
        grant_s = rr_gv_s;
      end
      default: begin
        g_s     = {SELW{1'b0}};
        grant_s = 1'b0;
      end
    endcase
  end

  // One-hot accept strobe and data mux; ready is held low while reset is asserted.
  always_comb begin
    ready_s = {N_CH{1'b0}};
    d_sel_s = {DW{1'b0}};
    for (int i = 0; i < N_CH; i++) begin
      ready_s[i] = !rst && load_s && grant_s && (int'(g_s) == i);
      d_sel_s    = (int'(g_s) == i) ? bus.d_in[i*DW +: DW] : d_sel_s;
    end
  end

  // Output register and round-robin pointer; pointer only advances on RR transfers.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_out_r   <= {DW{1'b0}};
      m_ch_r    <= {SELW{1'b0}};
      m_valid_r <= 1'b0;
      rr_ptr_r  <= {SELW{1'b0}};
    end else if (load_s) begin
      if (grant_s) begin
        m_out_r   <= d_sel_s;
        m_ch_r    <= g_s;
        m_valid_r <= 1'b1;
        if (bus.mode_in == MUX_RR) begin
          rr_ptr_r <= SELW'(wrap_add(int'(g_s), 1, N_CH));
        end else begin
          rr_ptr_r <= rr_ptr_r;
        end
      end else begin
        m_valid_r <= 1'b0;
      end
    end else begin
      m_valid_r <= m_valid_r;
    end
  end

  assign bus.ready_out   = ready_s;
  assign bus.m_out       = m_out_r;
  assign bus.m_ch_out    = m_ch_r;
  assign bus.m_valid_out = m_valid_r;

endmodule

// File: tb/tb_mux_arb_nxw.sv
// Testbench for mux_arb_nxw: two instances (3x16 and 5x32) share one stimulus stream.
// A table of vectors and hand-written sequences check the 3-channel instance against
// constants; a queue-free arithmetic reference model checks both instances every cycle,
// including a long randomized phase.
module tb_mux_arb_nxw;
  import mux_arb_nxw_pkg::*;

  logic        clk;
  logic        rst;
  logic        mode;
  logic [2:0]  sel;
  logic [4:0]  valid;
  logic        mrdy;
  logic [31:0] d [5];

  int pass_cnt = 0;
  int total_cnt = 0;

  mux_arb_nxw_if #(.N_CH(3), .DW(16)) b3 ();
  mux_arb_nxw_if #(.N_CH(5), .DW(32)) b5 ();

  mux_arb_nxw #(.N_CH(3), .DW(16)) dut3 (.clk(clk), .rst(rst), .bus(b3.slave));
  mux_arb_nxw #(.N_CH(5), .DW(32)) dut5 (.clk(clk), .rst(rst), .bus(b5.slave));

  assign b3.mode_in    = mode ? MUX_RR : MUX_SEL;
  assign b3.sel_in     = sel[1:0];
  assign b3.valid_in   = valid[2:0];
  assign b3.d_in       = {d[2][15:0], d[1][15:0], d[0][15:0]};
  assign b3.m_ready_in = mrdy;
  assign b5.mode_in    = mode ? MUX_RR : MUX_SEL;
  assign b5.sel_in     = sel;
  assign b5.valid_in   = valid;
  assign b5.d_in       = {d[4], d[3], d[2], d[1], d[0]};
  assign b5.m_ready_in = mrdy;

  always #5 clk = ~clk;

  // Reference model state per instance (0: 3x16, 1: 5x32).
  logic        md_mv   [2];
  logic [31:0] md_out  [2];
  int          md_ch   [2];
  int          md_ptr  [2];
  int          md_g    [2];
  bit          md_gv   [2];
  bit          md_load [2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [4:0] obs_ready(input int k);
    if (k == 1) return b5.ready_out;
    else return {2'b00, b3.ready_out};
  endfunction

  function automatic logic [31:0] obs_out(input int k);
    if (k == 1) return b5.m_out;
    else return {16'h0000, b3.m_out};
  endfunction

  function automatic logic [2:0] obs_ch(input int k);
    if (k == 1) return b5.m_ch_out;
    else return {1'b0, b3.m_ch_out};
  endfunction

  function automatic logic obs_mv(input int k);
    if (k == 1) return b5.m_valid_out;
    else return b3.m_valid_out;
  endfunction

  // Compute expected grant from the rules and compare against both DUTs (at negedge).
  task automatic model_check();
    for (int k = 0; k < 2; k++) begin
      int n;
      int s;
      logic [4:0] er;
      n = (k == 1) ? 5 : 3;
      s = (k == 1) ? int'(sel) : int'(sel[1:0]);
      md_load[k] = !md_mv[k] || mrdy;
      md_gv[k] = 1'b0;
      md_g[k] = 0;
      if (mode) begin
        for (int j = 0; j < n; j++) begin
          if (!md_gv[k] && valid[(md_ptr[k] + j) % n]) begin
            md_gv[k] = 1'b1;
            md_g[k] = (md_ptr[k] + j) % n;
          end
        end
      end else if (s < n && valid[s]) begin
        md_gv[k] = 1'b1;
        md_g[k] = s;
      end
      er = 5'b00000;
      if (!rst && md_load[k] && md_gv[k]) er[md_g[k]] = 1'b1;
      chk($sformatf("model%0d ready", k), 64'(obs_ready(k)), 64'(er));
      chk($sformatf("model%0d m_valid", k), 64'(obs_mv(k)), 64'(md_mv[k]));
      if (md_mv[k]) begin
        chk($sformatf("model%0d m_out", k), 64'(obs_out(k)), 64'(md_out[k]));
        chk($sformatf("model%0d m_ch", k), 64'(obs_ch(k)), 64'(md_ch[k]));
      end
    end
  endtask

  task automatic model_update();
    for (int k = 0; k < 2; k++) begin
      int n;
      n = (k == 1) ? 5 : 3;
      if (rst) begin
        md_mv[k] = 1'b0; md_out[k] = 32'h0; md_ch[k] = 0; md_ptr[k] = 0;
      end else if (md_load[k]) begin
        if (md_gv[k]) begin
          md_mv[k]  = 1'b1;
          md_out[k] = (k == 1) ? d[md_g[k]] : {16'h0000, d[md_g[k]][15:0]};
          md_ch[k]  = md_g[k];
          if (mode) md_ptr[k] = (md_g[k] + 1) % n;
        end else begin
          md_mv[k] = 1'b0;
        end
      end
    end
  endtask

  task automatic at_neg();
    @(negedge clk);
    model_check();
  endtask

  task automatic at_pos();
    @(posedge clk);
    model_update();
    #1;
  endtask

  // Apply one cycle of stimulus and check the 3-channel instance against constants.
  task automatic vec3(input string nm, input bit r, input bit m, input logic [2:0] s,
                      input logic [2:0] v, input bit rd, input logic [2:0] er,
                      input bit emv, input int ech, input logic [15:0] eout, input bit cd);
    rst = r; mode = m; sel = s; valid = {2'b00, v}; mrdy = rd;
    at_neg();
    chk({nm, " ready"}, 64'(b3.ready_out), 64'(er));
    chk({nm, " m_valid"}, 64'(b3.m_valid_out), 64'(emv));
    if (cd) begin
      chk({nm, " m_out"}, 64'(b3.m_out), 64'(eout));
      chk({nm, " m_ch"}, 64'(b3.m_ch_out), 64'(ech));
    end
    at_pos();
  endtask

  typedef struct {
    bit         r;
    bit         m;
    logic [2:0] s;
    logic [2:0] v;
    logic [15:0] d2;
    logic [2:0] er;
    bit         emv;
    int         ech;
    logic [15:0] eout;
    bit         cd;
  } vec_t;

  vec_t tbl [16];

  initial begin
    // Reset, explicit select (incl. out-of-range index), RR fairness on 111 then 101.
    tbl[0]  = '{1'b1, 1'b0, 3'd0, 3'b111, 16'hBEEF, 3'b000, 1'b0, 0, 16'h0000, 1'b1};
    tbl[1]  = '{1'b0, 1'b0, 3'd2, 3'b100, 16'hBEEF, 3'b100, 1'b0, 0, 16'h0000, 1'b1};
    tbl[2]  = '{1'b0, 1'b0, 3'd3, 3'b100, 16'hBEEF, 3'b000, 1'b1, 2, 16'hBEEF, 1'b1};
    tbl[3]  = '{1'b0, 1'b0, 3'd3, 3'b111, 16'h0003, 3'b000, 1'b0, 0, 16'h0000, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 3'd0, 3'b111, 16'h0003, 3'b001, 1'b0, 0, 16'h0000, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 3'd0, 3'b111, 16'h0003, 3'b010, 1'b1, 0, 16'h0001, 1'b1};
    tbl[6]  = '{1'b0, 1'b1, 3'd0, 3'b111, 16'h0003, 3'b100, 1'b1, 1, 16'h0002, 1'b1};
    tbl[7]  = '{1'b0, 1'b1, 3'd0, 3'b111, 16'h0003, 3'b001, 1'b1, 2, 16'h0003, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 3'd0, 3'b111, 16'h0003, 3'b010, 1'b1, 0, 16'h0001, 1'b1};
    tbl[9]  = '{1'b0, 1'b1, 3'd0, 3'b111, 16'h0003, 3'b100, 1'b1, 1, 16'h0002, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 3'd0, 3'b101, 16'h0003, 3'b001, 1'b1, 2, 16'h0003, 1'b1};
    tbl[11] = '{1'b0, 1'b1, 3'd0, 3'b101, 16'h0003, 3'b100, 1'b1, 0, 16'h0001, 1'b1};
    tbl[12] = '{1'b0, 1'b1, 3'd0, 3'b101, 16'h0003, 3'b001, 1'b1, 2, 16'h0003, 1'b1};
    tbl[13] = '{1'b0, 1'b1, 3'd0, 3'b101, 16'h0003, 3'b100, 1'b1, 0, 16'h0001, 1'b1};
    tbl[14] = '{1'b0, 1'b1, 3'd0, 3'b000, 16'h0003, 3'b000, 1'b1, 2, 16'h0003, 1'b1};
    tbl[15] = '{1'b0, 1'b1, 3'd0, 3'b000, 16'h0003, 3'b000, 1'b0, 0, 16'h0000, 1'b0};

    clk = 1'b0;
    rst = 1'b1; mode = 1'b0; sel = 3'd0; valid = 5'b00111; mrdy = 1'b1;
    d[0] = 32'h0000_0001; d[1] = 32'h0000_0002; d[2] = 32'h0000_BEEF;
    d[3] = 32'h0000_0004; d[4] = 32'h0000_0005;
    @(posedge clk);
    model_update();
    #1;

    for (int i = 0; i < 16; i++) begin
      d[2] = {16'h0000, tbl[i].d2};
      vec3($sformatf("tbl%0d", i), tbl[i].r, tbl[i].m, tbl[i].s, tbl[i].v, 1'b1,
           tbl[i].er, tbl[i].emv, tbl[i].ech, tbl[i].eout, tbl[i].cd);
    end

    // Backpressure: AAAA held through 3 stalled cycles, then ch1 follows.
    d[0] = 32'h0000_AAAA; d[1] = 32'h0000_5555;
    vec3("bp_load", 1'b0, 1'b1, 3'd0, 3'b001, 1'b1, 3'b001, 1'b0, 0, 16'h0000, 1'b0);
    for (int i = 0; i < 3; i++)
      vec3($sformatf("bp_stall%0d", i), 1'b0, 1'b1, 3'd0, 3'b011, 1'b0, 3'b000, 1'b1, 0, 16'hAAAA, 1'b1);
    vec3("bp_release", 1'b0, 1'b1, 3'd0, 3'b011, 1'b1, 3'b010, 1'b1, 0, 16'hAAAA, 1'b1);

    // Mode switch: SEL transfers leave the pointer at 2, so RR resumes at ch2.
    d[0] = 32'h0000_0A0A;
    vec3("ms_sel0", 1'b0, 1'b0, 3'd0, 3'b001, 1'b1, 3'b001, 1'b1, 1, 16'h5555, 1'b1);
    vec3("ms_sel1", 1'b0, 1'b0, 3'd0, 3'b001, 1'b1, 3'b001, 1'b1, 0, 16'h0A0A, 1'b1);
    vec3("ms_rr",   1'b0, 1'b1, 3'd0, 3'b111, 1'b1, 3'b100, 1'b1, 0, 16'h0A0A, 1'b1);

    // Reset mid-stream drops held data and rewinds the pointer to ch0.
    vec3("rs_pre",  1'b0, 1'b1, 3'd0, 3'b111, 1'b1, 3'b001, 1'b1, 2, 16'h0003, 1'b1);
    vec3("rs_rst",  1'b1, 1'b1, 3'd0, 3'b111, 1'b1, 3'b000, 1'b1, 0, 16'h0A0A, 1'b1);
    vec3("rs_post", 1'b0, 1'b1, 3'd0, 3'b111, 1'b1, 3'b001, 1'b0, 0, 16'h0000, 1'b1);
    vec3("rs_next", 1'b0, 1'b1, 3'd0, 3'b111, 1'b1, 3'b010, 1'b1, 0, 16'h0A0A, 1'b1);

    // Randomized traffic on both instances, checked by the reference model only.
    for (int c = 0; c < 800; c++) begin
      rst   = ($urandom_range(0, 49) == 0);
      mode  = ($urandom_range(0, 3) != 0);
      sel   = 3'($urandom_range(0, 7));
      valid = 5'($urandom);
      mrdy  = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 5; i++) d[i] = $urandom;
      at_neg();
      at_pos();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
